// File: rtl/div_ratio_ctrl_if.sv
// Ratio-change request channel from the register file to the divider controller.
// The requester holds valid until ready; rejected requests come back on o_cfg_err.
interface div_ratio_ctrl_if #(
    parameter int RATIO_W = 8
);
    logic               i_cfg_valid;
    logic [RATIO_W-1:0] i_cfg_ratio;
    logic               o_cfg_ready;
    logic               o_cfg_err;

    modport master (
        output i_cfg_valid,
        output i_cfg_ratio,
        input  o_cfg_ready,
        input  o_cfg_err
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_ratio,
        output o_cfg_ready,
        output o_cfg_err
    );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Owns the clock divider's ratio and enable. A new ratio is loaded only at a divided-period
// boundary, and only after the divider has been gated off for SETTLE_CYC reference cycles.
module div_ratio_ctrl #(
    parameter int RATIO_W       = 8,
    parameter int SETTLE_CYC    = 4,
    parameter int DEFAULT_RATIO = 8
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    div_ratio_ctrl_if.slave    cfg,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GATE,
        RESUME
    } state_t;

    localparam logic [RATIO_W-1:0] RATIO_RST   = RATIO_W'(DEFAULT_RATIO);
    localparam logic [RATIO_W-1:0] ONE         = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t             state;
    logic [RATIO_W-1:0] mirror_cnt;
    logic [RATIO_W-1:0] pending;
    logic [3:0]         settle_cnt;
    logic               cfg_err;
    logic               ratio_ge2;
    logic               boundary;

    // Ratio-1 is only meaningful for ratios >= 2, so the compare never sees an underflow.
    assign ratio_ge2 = (o_div_ratio > ONE);
    assign boundary  = o_clk_en && ratio_ge2 && (mirror_cnt == o_div_ratio - ONE);

    assign cfg.o_cfg_ready = (state == IDLE);
    assign cfg.o_cfg_err   = cfg_err;
    assign o_busy          = (state != IDLE);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_div_ratio <= RATIO_RST;
            o_clk_en    <= 1'b0;
            cfg_err     <= 1'b0;
            mirror_cnt  <= '0;
            settle_cnt  <= '0;
            pending     <= '0;
        end else begin
            cfg_err <= 1'b0;

            if (state == RESUME || !o_clk_en || !ratio_ge2) begin
                mirror_cnt <= '0;
            end else if (mirror_cnt == o_div_ratio - ONE) begin
                mirror_cnt <= '0;
            end else begin
                mirror_cnt <= mirror_cnt + ONE;
            end

            case (state)
                IDLE: begin
                    o_clk_en <= i_enable;
                    if (cfg.i_cfg_valid) begin
                        if (cfg.i_cfg_ratio == '0) begin
                            cfg_err <= 1'b1;
                        end else if (cfg.i_cfg_ratio != o_div_ratio) begin
                            pending    <= cfg.i_cfg_ratio;
                            settle_cnt <= '0;
                            // A stopped or bypassed divider has no period to finish.
                            if (!o_clk_en || !ratio_ge2) begin
                                o_clk_en <= 1'b0;
                                state    <= GATE;
                            end else begin
                                o_clk_en <= 1'b1;
                                state    <= DRAIN;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (boundary || !i_enable) begin
                        o_clk_en   <= 1'b0;
                        settle_cnt <= '0;
                        state      <= GATE;
                    end
                end

                GATE: begin
                    o_clk_en   <= 1'b0;
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        o_div_ratio <= pending;
                        state       <= RESUME;
                    end
                end

                RESUME: begin
                    o_clk_en <= i_enable;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
